head_ptr_writer: RTL and testbench

- Write-side master of the bucket head-pointer RAM. It takes head-pointer update requests from the insert engine and the delete engine and serialises them into one ordered write stream.
- Drives the head table write port: wr_addr, wr_data_ptr, wr_data_ptr_val, wr_en.
- Holds writes back while a RAM clear is in progress.
- Exposes a pending-bucket lookup so the read side can backpressure on buckets whose update has not yet reached the RAM.

---
 rtl/head_ptr_writer_pkg.sv | 19 +
 rtl/head_ptr_writer_fifo.sv | 55 +++++
 rtl/head_ptr_writer.sv | 92 +++++++++
 tb/tb_head_ptr_writer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/head_ptr_writer_pkg.sv
// Shared hash-table types: one head-pointer update as carried from the
// insert/delete engines to the head RAM write port.
package hash_table;

  localparam int BUCKET_WIDTH   = 8;
  localparam int HEAD_PTR_WIDTH = 10;

  typedef struct packed {
    logic [BUCKET_WIDTH-1:0]   bucket;
    logic [HEAD_PTR_WIDTH-1:0] ptr;
    logic                      ptr_val;
  } head_upd_t;

  typedef enum logic {
    SIDE_INS = 1'b0,
    SIDE_DEL = 1'b1
  } side_e;

endpackage

// File: rtl/head_ptr_writer_fifo.sv
// Circular queue of pending head updates; pointers carry one extra wrap bit.
// Exposes every slot plus a per-slot valid vector for the pending-bucket compare.
module head_upd_fifo
  import hash_table::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  head_upd_t        push_dat,
  input  logic             pop,
  output head_upd_t        head,
  output logic             full,
  output logic             empty,
  output logic             empty_next,
  output head_upd_t        entries [DEPTH],
  output logic [DEPTH-1:0] entry_vld
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] wr_ptr_nxt, rd_ptr_nxt;
  head_upd_t   mem [DEPTH];

  assign wr_ptr_nxt = wr_ptr + (AW+1)'(push);
  assign rd_ptr_nxt = rd_ptr + (AW+1)'(pop);

  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign empty_next = (wr_ptr_nxt == rd_ptr_nxt);
  assign head       = mem[rd_ptr[AW-1:0]];
  assign entries    = mem;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  // Push is never allowed when full and pop never when empty, so the two
  // slot indices touched here are always distinct.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      entry_vld <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (push) entry_vld[wr_ptr[AW-1:0]] <= 1'b1;
      if (pop)  entry_vld[rd_ptr[AW-1:0]] <= 1'b0;
    end
  end

endmodule

// File: rtl/head_ptr_writer.sv
// Round-robin merge of insert/delete head updates into one ordered head RAM
// write stream; writes are held while the RAM clear runs.
module head_ptr_writer
  import hash_table::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int A_WIDTH    = BUCKET_WIDTH,
  parameter int P_WIDTH    = HEAD_PTR_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  head_upd_t          ins_req_i,
  input  logic               ins_valid_i,
  output logic               ins_ready_o,
  input  head_upd_t          del_req_i,
  input  logic               del_valid_i,
  output logic               del_ready_o,
  input  logic               clear_busy_i,
  output logic [A_WIDTH-1:0] wr_addr_o,
  output logic [P_WIDTH-1:0] wr_data_ptr_o,
  output logic               wr_data_ptr_val_o,
  output logic               wr_en_o,
  input  logic [A_WIDTH-1:0] lookup_bucket_i,
  output logic               lookup_hit_o,
  output logic               idle_o,
  output logic [31:0]        wr_cnt_o
);

  side_e                 prio;
  logic                  ins_acc, del_acc, push, pop;
  logic                  full, empty, empty_next;
  head_upd_t             push_dat, head;
  head_upd_t             fifo_entries [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_vld;

  // prio names the side that wins a tie; it moves to the other side after
  // every grant, so the last winner loses the next contested cycle.
  assign ins_ready_o = !rst_i && !full && (!del_valid_i || prio == SIDE_INS);
  assign del_ready_o = !rst_i && !full && (!ins_valid_i || prio == SIDE_DEL);

  assign ins_acc  = ins_valid_i && ins_ready_o;
  assign del_acc  = del_valid_i && del_ready_o;
  assign push     = ins_acc || del_acc;
  assign push_dat = ins_acc ? ins_req_i : del_req_i;
  assign pop      = !empty && !clear_busy_i;

  head_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push       (push),
    .push_dat   (push_dat),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .empty_next (empty_next),
    .entries    (fifo_entries),
    .entry_vld  (fifo_vld)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio              <= SIDE_INS;
      wr_en_o           <= 1'b0;
      wr_addr_o         <= '0;
      wr_data_ptr_o     <= '0;
      wr_data_ptr_val_o <= 1'b0;
      idle_o            <= 1'b1;
      wr_cnt_o          <= '0;
    end else begin
      if (ins_acc)      prio <= SIDE_DEL;
      else if (del_acc) prio <= SIDE_INS;
      wr_en_o <= pop;
      if (pop) begin
        wr_addr_o         <= A_WIDTH'(head.bucket);
        wr_data_ptr_o     <= P_WIDTH'(head.ptr);
        wr_data_ptr_val_o <= head.ptr_val;
      end
      idle_o <= empty_next && !pop;
      if (wr_en_o) wr_cnt_o <= wr_cnt_o + 32'd1;
    end
  end

  always_comb begin
    lookup_hit_o = wr_en_o && (wr_addr_o == lookup_bucket_i);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_vld[i] && (A_WIDTH'(fifo_entries[i].bucket) == lookup_bucket_i))
        lookup_hit_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_head_ptr_writer.sv
// Directed bench for head_ptr_writer: expected writes are queued when stimulus
// is issued and a negedge monitor pops and compares every wr_en_o cycle.
module tb_head_ptr_writer;
  import hash_table::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  head_upd_t   ins_req_i, del_req_i;
  logic        ins_valid_i, ins_ready_o, del_valid_i, del_ready_o;
  logic        clear_busy_i;
  logic [BUCKET_WIDTH-1:0]   wr_addr_o, lookup_bucket_i;
  logic [HEAD_PTR_WIDTH-1:0] wr_data_ptr_o;
  logic        wr_data_ptr_val_o, wr_en_o, lookup_hit_o, idle_o;
  logic [31:0] wr_cnt_o;

  int tests = 0;
  int fails = 0;
  head_upd_t sb[$];
  head_upd_t mon_exp;

  always #5 clk_i = ~clk_i;

  head_ptr_writer #(.FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ins_req_i(ins_req_i), .ins_valid_i(ins_valid_i), .ins_ready_o(ins_ready_o),
    .del_req_i(del_req_i), .del_valid_i(del_valid_i), .del_ready_o(del_ready_o),
    .clear_busy_i(clear_busy_i),
    .wr_addr_o(wr_addr_o), .wr_data_ptr_o(wr_data_ptr_o),
    .wr_data_ptr_val_o(wr_data_ptr_val_o), .wr_en_o(wr_en_o),
    .lookup_bucket_i(lookup_bucket_i), .lookup_hit_o(lookup_hit_o),
    .idle_o(idle_o), .wr_cnt_o(wr_cnt_o)
  );

  function automatic head_upd_t mk(input int b, input int p, input bit v);
    head_upd_t u;
    u.bucket  = BUCKET_WIDTH'(b);
    u.ptr     = HEAD_PTR_WIDTH'(p);
    u.ptr_val = v;
    return u;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (!idle_o && k < 60) begin
      tick();
      k++;
    end
    chk(name, {31'd0, idle_o}, 32'd1);
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && wr_en_o) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr 0x%0h ptr 0x%0h with nothing expected at %0t",
                 wr_addr_o, wr_data_ptr_o, $time);
      end else begin
        mon_exp = sb.pop_front();
        chk("write_addr", 32'(wr_addr_o), 32'(mon_exp.bucket));
        chk("write_ptr", 32'(wr_data_ptr_o), 32'(mon_exp.ptr));
        chk("write_ptr_val", {31'd0, wr_data_ptr_val_o}, {31'd0, mon_exp.ptr_val});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, 0 != 1");
    $fatal(1, "watchdog");
  end

  initial begin
    int ii, di, acc, wen_seen, cyc;
    bit ia, da;

    rst_i = 1'b1; ins_valid_i = 1'b0; del_valid_i = 1'b0; clear_busy_i = 1'b0;
    ins_req_i = '0; del_req_i = '0; lookup_bucket_i = '0;
    #2;
    chk("rst_ins_ready", {31'd0, ins_ready_o}, 32'd0);
    chk("rst_del_ready", {31'd0, del_ready_o}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en_o}, 32'd0);
    chk("rst_wr_addr", 32'(wr_addr_o), 32'd0);
    chk("rst_idle", {31'd0, idle_o}, 32'd1);
    chk("rst_wr_cnt", wr_cnt_o, 32'd0);
    tick(); tick();
    rst_i = 1'b0;
    tick();

    // Both sides valid: strict ins/del alternation starting with ins.
    for (int k = 0; k < 8; k++) begin
      sb.push_back(mk(k, 16 + k, 1'b1));
      sb.push_back(mk(100 + k, 200 + k, 1'b0));
    end
    ii = 0; di = 0; cyc = 0;
    while ((ii < 8 || di < 8) && cyc < 100) begin
      ins_valid_i = (ii < 8); ins_req_i = mk(ii, 16 + ii, 1'b1);
      del_valid_i = (di < 8); del_req_i = mk(100 + di, 200 + di, 1'b0);
      @(negedge clk_i);
      ia = ins_valid_i && ins_ready_o;
      da = del_valid_i && del_ready_o;
      tick();
      if (ia) ii++;
      if (da) di++;
      cyc++;
    end
    ins_valid_i = 1'b0; del_valid_i = 1'b0;
    chk("alt_all_accepted", 32'(ii + di), 32'd16);
    wait_idle("alt_idle");
    chk("alt_sb_drained", 32'(sb.size()), 32'd0);
    chk("alt_wr_cnt", wr_cnt_o, 32'd16);

    // Single insert into an empty queue.
    ins_req_i = mk(5, 9, 1'b1); ins_valid_i = 1'b1;
    sb.push_back(mk(5, 9, 1'b1));
    @(negedge clk_i);
    chk("single_ready", {31'd0, ins_ready_o}, 32'd1);
    tick();
    ins_valid_i = 1'b0;
    @(negedge clk_i);
    chk("single_wr_en_c0", {31'd0, wr_en_o}, 32'd0);
    tick();
    @(negedge clk_i);
    chk("single_wr_en_c1", {31'd0, wr_en_o}, 32'd1);
    chk("single_busy", {31'd0, idle_o}, 32'd0);
    tick();
    @(negedge clk_i);
    chk("single_wr_en_c2", {31'd0, wr_en_o}, 32'd0);
    chk("single_idle", {31'd0, idle_o}, 32'd1);
    chk("single_wr_cnt", wr_cnt_o, 32'd17);
    tick();

    // Clear in progress: 6 inserts offered, only 4 fit, nothing written.
    for (int k = 0; k < 6; k++) sb.push_back(mk(20 + k, 40 + k, 1'b1));
    clear_busy_i = 1'b1; acc = 0; wen_seen = 0;
    for (int c = 0; c < 10; c++) begin
      ins_valid_i = (acc < 6); ins_req_i = mk(20 + acc, 40 + acc, 1'b1);
      @(negedge clk_i);
      ia = ins_valid_i && ins_ready_o;
      if (wr_en_o) wen_seen++;
      tick();
      if (ia) acc++;
    end
    chk("clear_accepts", 32'(acc), 32'd4);
    chk("clear_ready_low", {31'd0, ins_ready_o}, 32'd0);
    chk("clear_no_writes", 32'(wen_seen), 32'd0);
    clear_busy_i = 1'b0; cyc = 0;
    while (acc < 6 && cyc < 50) begin
      ins_valid_i = 1'b1; ins_req_i = mk(20 + acc, 40 + acc, 1'b1);
      @(negedge clk_i);
      ia = ins_ready_o;
      tick();
      if (ia) acc++;
      cyc++;
    end
    ins_valid_i = 1'b0;
    chk("clear_rest_accepted", 32'(acc), 32'd6);
    wait_idle("clear_idle");
    chk("clear_sb_drained", 32'(sb.size()), 32'd0);

    // Lookup: queue {3,7}, output register holding 9.
    sb.push_back(mk(9, 1, 1'b1)); sb.push_back(mk(3, 2, 1'b1)); sb.push_back(mk(7, 3, 1'b0));
    clear_busy_i = 1'b1;
    ins_valid_i = 1'b1; ins_req_i = mk(9, 1, 1'b1); tick();
    ins_req_i = mk(3, 2, 1'b1); tick();
    ins_req_i = mk(7, 3, 1'b0); tick();
    ins_valid_i = 1'b0; clear_busy_i = 1'b0;
    tick();
    clear_busy_i = 1'b1;
    @(negedge clk_i);
    chk("lookup_wr_en", {31'd0, wr_en_o}, 32'd1);
    lookup_bucket_i = 8'd3; #1 chk("lookup_3_hit", {31'd0, lookup_hit_o}, 32'd1);
    lookup_bucket_i = 8'd7; #1 chk("lookup_7_hit", {31'd0, lookup_hit_o}, 32'd1);
    lookup_bucket_i = 8'd9; #1 chk("lookup_9_hit", {31'd0, lookup_hit_o}, 32'd1);
    lookup_bucket_i = 8'd4; #1 chk("lookup_4_miss", {31'd0, lookup_hit_o}, 32'd0);
    tick();
    clear_busy_i = 1'b0;
    wait_idle("lookup_idle");
    lookup_bucket_i = 8'd3; #1 chk("lookup_3_drained", {31'd0, lookup_hit_o}, 32'd0);
    lookup_bucket_i = 8'd9; #1 chk("lookup_9_drained", {31'd0, lookup_hit_o}, 32'd0);
    chk("lookup_sb_drained", 32'(sb.size()), 32'd0);

    // Counter wrap from 0xFFFFFFFF.
    @(negedge clk_i);
    force dut.wr_cnt_o = 32'hFFFF_FFFF;
    #1 release dut.wr_cnt_o;
    #1 chk("wrap_preload", wr_cnt_o, 32'hFFFF_FFFF);
    tick();
    sb.push_back(mk(11, 12, 1'b1));
    ins_valid_i = 1'b1; ins_req_i = mk(11, 12, 1'b1);
    tick();
    ins_valid_i = 1'b0;
    wait_idle("wrap_idle");
    chk("wrap_cnt", wr_cnt_o, 32'd0);

    // Reset with 3 entries queued behind a clear.
    clear_busy_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ins_valid_i = 1'b1; ins_req_i = mk(33 + k, 50 + k, 1'b1); tick();
    end
    ins_req_i = mk(36, 53, 1'b1);
    chk("prerst_busy", {31'd0, idle_o}, 32'd0);
    rst_i = 1'b1;
    #1;
    chk("midrst_wr_en", {31'd0, wr_en_o}, 32'd0);
    chk("midrst_idle", {31'd0, idle_o}, 32'd1);
    chk("midrst_ins_ready", {31'd0, ins_ready_o}, 32'd0);
    chk("midrst_del_ready", {31'd0, del_ready_o}, 32'd0);
    chk("midrst_wr_cnt", wr_cnt_o, 32'd0);
    lookup_bucket_i = 8'd33; #1 chk("midrst_lookup", {31'd0, lookup_hit_o}, 32'd0);
    ins_valid_i = 1'b0; clear_busy_i = 1'b0;
    tick();
    rst_i = 1'b0;
    repeat (10) tick();
    chk("postrst_idle", {31'd0, idle_o}, 32'd1);
    chk("postrst_wr_cnt", wr_cnt_o, 32'd0);
    chk("postrst_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
